add_seq: RTL

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_seq
// Purpose  : Command sequencer for a vector add unit. For each of cmd_len
//            N-byte vectors it fetches operand A, fetches operand B, starts
//            the add, then stores the result, stepping every address by N.
// Revision : 1.0 - initial release
//
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            cmd_*               - valid/ready command interface
//            abort               - synchronous cancel of the running command
//            u_*                 - add-unit control (scales, strobes, address)
//            wr_req/addr/ack     - result store handshake
//            busy, done          - status; done pulses on normal completion
//            perf_cycles         - busy-cycle counter
//
// Options  : ADD_SEQ_PERF_CNT_EN - enables perf_cycles; otherwise tied to 0.
// ============================================================================
module add_seq #(
    parameter int N  = 176,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [AW-1:0] cmd_addr_c,
    input  logic [15:0]   cmd_len,
    input  logic [15:0]   cmd_s_a,
    input  logic [15:0]   cmd_s_b,
    input  logic [7:0]    cmd_z_tot,
    input  logic          abort,
    output logic [15:0]   u_s_a,
    output logic [15:0]   u_s_b,
    output logic [7:0]    u_z_tot,
    output logic          u_fetch,
    output logic          u_fetch_sel,
    output logic          u_exec,
    output logic [AW-1:0] u_fetch_addr,
    input  logic          u_done,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    input  logic          wr_ack,
    output logic          busy,
    output logic          done,
    output logic [31:0]   perf_cycles
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        EXEC    = 3'd3,
        STORE   = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_stride = AW'(N);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_first;      // high during the first cycle of a state
    logic [AW-1:0] r_addr_a;
    logic [AW-1:0] r_addr_b;
    logic [AW-1:0] r_addr_c;
    logic [15:0]   r_len;
    logic [15:0]   r_k;
    logic [AW-1:0] r_off;        // k*N kept incrementally, wraps modulo 2^AW
    logic [15:0]   r_s_a;
    logic [15:0]   r_s_b;
    logic [7:0]    r_z_tot;

    logic          w_idle;
    logic          w_accept;
    logic          w_advance;
    logic          w_live;       // non-IDLE state not being aborted this cycle
    logic [15:0]   w_k_inc;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = cmd_valid && w_idle;
    assign w_k_inc  = r_k + 16'd1;
    assign w_live   = !w_idle && !abort;

    // Next-state logic. u_done is ignored in the strobe cycle so a unit that
    // still reports completion of the previous step cannot skip a step.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (cmd_len == 16'd0) ? FIN : FETCH_A;
                end
            end
            FETCH_A: if (!r_first && u_done) w_state_next = FETCH_B;
            FETCH_B: if (!r_first && u_done) w_state_next = EXEC;
            EXEC:    if (!r_first && u_done) w_state_next = STORE;
            STORE: begin
                if (wr_ack) begin
                    w_advance    = 1'b1;
                    w_state_next = (w_k_inc == r_len) ? FIN : FETCH_A;
                end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // Abort wins over any handshake arriving in the same cycle.
        if (abort && !w_idle) begin
            w_state_next = IDLE;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_first  <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_c <= '0;
            r_len    <= '0;
            r_k      <= '0;
            r_off    <= '0;
            r_s_a    <= '0;
            r_s_b    <= '0;
            r_z_tot  <= '0;
        end else begin
            r_state <= w_state_next;
            r_first <= (w_state_next != r_state);
            if (w_accept) begin
                r_addr_a <= cmd_addr_a;
                r_addr_b <= cmd_addr_b;
                r_addr_c <= cmd_addr_c;
                r_len    <= cmd_len;
                r_k      <= '0;
                r_off    <= '0;
                r_s_a    <= cmd_s_a;
                r_s_b    <= cmd_s_b;
                r_z_tot  <= cmd_z_tot;
            end else if (w_advance) begin
                r_k   <= w_k_inc;
                r_off <= r_off + c_stride;
            end
        end
    end

    // Outputs. Strobes and done are suppressed in a cycle carrying abort.
    assign cmd_ready    = w_idle;
    assign busy         = !w_idle;
    assign u_s_a        = r_s_a;
    assign u_s_b        = r_s_b;
    assign u_z_tot      = r_z_tot;
    assign u_fetch      = w_live && r_first && ((r_state == FETCH_A) || (r_state == FETCH_B));
    assign u_fetch_sel  = (r_state == FETCH_B);
    assign u_exec       = w_live && r_first && (r_state == EXEC);
    assign wr_req       = w_live && (r_state == STORE);
    assign done         = w_live && (r_state == FIN);
    assign u_fetch_addr = (r_state == FETCH_A) ? (r_addr_a + r_off) :
                          (r_state == FETCH_B) ? (r_addr_b + r_off) : '0;
    assign wr_addr      = (r_state == STORE) ? (r_addr_c + r_off) : '0;

`ifdef ADD_SEQ_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (!w_idle && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire
